// File: rtl/seq_unrotator_pkg.sv
// Shared constants for the rotate/unrotate shifter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_unrotator_pkg;

  // Default datapath geometry: an 8-bit word rotated by a 3-bit amount.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 3;

  // Control FSM encoding; 2'd3 is unused and decodes back to idle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_unrotator_rotl1_step.sv
// Single-position rotate-left of a WIDTH-bit word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake at this level.
import seq_unrotator_pkg::*;

module rotl1_step #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // The MSB wraps around into bit 0; every other bit moves up one place.
  assign dout = {din[WIDTH-2:0], din[WIDTH-1]};

endmodule

// File: rtl/seq_unrotator.sv
// Iterative inverse of the rotate-right barrel shifter: rotates left one bit per clock.
// Latency: out_valid rises in_amnt edges after the accept edge (accept edge plus in_amnt shift edges).
// Backpressure: out_data held in DONE until out_ready; in_ready only high while idle.
import seq_unrotator_pkg::*;

module seq_unrotator #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_rot;
  logic [AMT_W-1:0] cnt;
  logic             accept;
  logic             release_out;

  // Handshakes are qualified by the state-decoded ready/valid only, so no
  // input reaches an output combinationally.
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;

  // One-bit left rotate of the working word, feeding the SHIFT update.
  rotl1_step #(
    .WIDTH (WIDTH)
  ) u_rotl1 (
    .din  (data_reg),
    .dout (data_rot)
  );

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: capture on accept, then rotate and count down while shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_reg <= in_data;
            cnt      <= in_amnt;
          end
        end
        ST_SHIFT: begin
          // The counter is never decremented through zero.
          if (cnt != '0) begin
            data_reg <= data_rot;
            cnt      <= cnt - AMT_W'(1);
          end
        end
        default: begin
          data_reg <= data_reg;
          cnt      <= cnt;
        end
      endcase
    end
  end

  // Next-state decode: a zero amount skips straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (in_amnt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // cnt==1 is the last rotate; cnt==0 cannot occur here but must not stall.
        if (cnt <= AMT_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (release_out) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
  end

  assign out_data = data_reg;

endmodule

// File: tb/tb_seq_unrotator.sv
// Scoreboard bench for seq_unrotator: directed vectors plus an exhaustive round trip.
// Latency: expected first out_valid is in_amnt edges after the accept edge.
// Backpressure: out_ready is driven by the monitor (always, random, or held low).
module tb_seq_unrotator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amnt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  seq_unrotator #(
    .WIDTH (8),
    .AMT_W (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amnt   (in_amnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         amnt;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   hold  = 1'b0;
  bit   rnd   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Forward reference: the rotate-right the upstream shifter applies.
  function automatic logic [7:0] rotr(input logic [7:0] d, input int a);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < a; i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  // Present one word; must be called at a negedge. Returns at the negedge after accept.
  task automatic send(input logic [7:0] din, input int amt, input logic [7:0] expect_out);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = din;
    in_amnt  = 3'(amt);
    while (!in_ready && waited <= 60) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready) begin
      sb.push_back('{expect_out, amt, cyc + 1});
    end else begin
      check("accept_timeout", 32'(waited), 32'(0));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  // Monitor: owns out_ready, checks latency on each rise of out_valid and data on each handshake.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v    = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      out_ready = hold ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (rst) begin
        prev_v = 1'b0;
        continue;
      end
      if (out_valid && !prev_v) begin
        if (sb.size() != 0) check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].amnt));
        else check("unexpected_valid", 32'(out_data), 32'hFFFF_FFFF);
      end
      if (out_valid && out_ready) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
        end else begin
          check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_amnt  = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic restore.
    send(8'h96, 3, 8'hB4);
    drain();
    check("basic_in_ready_after", 32'(in_ready), 32'(1));
    check("basic_busy_after", 32'(busy), 32'(0));

    // Zero amount passes straight through.
    send(8'h5A, 0, 8'h5A);
    drain();
    check("zero_in_ready_after", 32'(in_ready), 32'(1));

    // Maximum amount: busy through 7 SHIFT cycles and 1 DONE cycle.
    send(8'h01, 7, 8'h80);
    for (int i = 0; i < 8; i++) begin
      check("max_busy", 32'(busy), 32'(1));
      @(negedge clk);
    end
    check("max_busy_after", 32'(busy), 32'(0));
    check("max_in_ready_after", 32'(in_ready), 32'(1));
    check("max_drained", 32'(sb.size()), 32'(0));

    // Backpressure: output held, stray in_valid pulses ignored.
    hold = 1'b1;
    send(8'h96, 3, 8'hB4);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_out_data", 32'(out_data), 32'hB4);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      in_valid = (i % 2 == 0);
      in_data  = 8'hFF;
      in_amnt  = 3'd2;
      @(negedge clk);
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'(1));
    check("bp_release_out_valid", 32'(out_valid), 32'(0));
    check("bp_drained", 32'(sb.size()), 32'(0));

    // Reset in the third SHIFT cycle drops the word in flight.
    send(8'hF0, 6, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_out_data", 32'(out_data), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    send(8'h96, 3, 8'hB4);
    drain();

    // Round trip over every data value and amount with random output stalls.
    rnd = 1'b1;
    for (int d = 0; d < 256; d++) begin
      for (int a = 0; a < 8; a++) begin
        send(rotr(8'(d), a), a, 8'(d));
      end
    end
    drain();
    rnd = 1'b0;
    repeat (3) @(negedge clk);
    check("final_idle", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
